// File: rtl/sparse_chunk_encoder.sv
// sparse_chunk_encoder: converts dense byte beats into a sparsemap plus
// left-packed nonzero bytes for the SRAM write port. Each beat is tagged
// with its beat index in the chunk and the SRAM chunk slot. Short chunks
// are zero-padded up to WR_DAT_CYC_NUM beats.

`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
`ifndef SRAM_IFM_NUM
`define SRAM_IFM_NUM 4
`endif

module sparse_chunk_encoder #(
    parameter int BUS_SIZE       = `BUS_SIZE,
    parameter int WR_DAT_CYC_NUM = `WR_DAT_CYC_NUM,
    parameter int SRAM_NUM       = `SRAM_IFM_NUM
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              dense_valid_i,
    output logic                              dense_ready_o,
    input  logic [BUS_SIZE*8-1:0]             dense_dat_i,
    input  logic                              dense_last_i,
    input  logic                              chunk_cnt_clr_i,
    output logic                              sram_wr_valid_o,
    output logic [BUS_SIZE-1:0]               sram_wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]             sram_wr_nonzero_data_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0] sram_wr_dat_count_o,
    output logic [$clog2(SRAM_NUM)-1:0]       sram_wr_chunk_count_o,
    output logic                              chunk_done_o
);

    localparam int BW   = $clog2(WR_DAT_CYC_NUM);
    localparam int CW   = $clog2(SRAM_NUM);
    localparam int IDXW = $clog2(BUS_SIZE) + 1;

    localparam logic [0:0] ST_ENC = 1'b0;
    localparam logic [0:0] ST_PAD = 1'b1;

    logic [0:0]            r_state;
    logic [BW-1:0]         r_beat;
    logic [CW-1:0]         r_chunk;
    logic                  r_valid;
    logic                  r_done;
    logic [BUS_SIZE-1:0]   r_map;
    logic [BUS_SIZE*8-1:0] r_data;
    logic [BW-1:0]         r_dat_count;
    logic [CW-1:0]         r_chunk_count;

    logic [BUS_SIZE-1:0]   w_map;
    logic [BUS_SIZE*8-1:0] w_packed;
    logic [IDXW-1:0]       w_pack_idx;
    logic                  w_hs;
    logic                  w_emit;
    logic                  w_beat_last;
    logic                  w_chunk_end;

    assign dense_ready_o = (r_state == ST_ENC) && !rst_i;
    assign w_hs          = dense_valid_i && dense_ready_o;
    // A beat leaves the encoder either from an accepted dense beat or a pad beat.
    assign w_emit        = w_hs || (r_state == ST_PAD);
    assign w_beat_last   = (r_beat == BW'(WR_DAT_CYC_NUM - 1));
    assign w_chunk_end   = w_emit && w_beat_last;

    generate
        for (genvar gi = 0; gi < BUS_SIZE; gi++) begin : g_map
            assign w_map[gi] = |dense_dat_i[gi*8 +: 8];
        end
    endgenerate

    // Left-pack nonzero bytes: the running index is the prefix popcount of the map.
    always_comb begin
        w_packed   = '0;
        w_pack_idx = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (w_map[i]) begin
                w_packed[w_pack_idx*8 +: 8] = dense_dat_i[i*8 +: 8];
                w_pack_idx = w_pack_idx + IDXW'(1);
            end
        end
    end

    // Control: ENC/PAD state, beat index within the chunk, chunk slot counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_ENC;
            r_beat  <= '0;
            r_chunk <= '0;
        end else begin
            if (w_emit) begin
                r_beat <= w_beat_last ? '0 : r_beat + BW'(1);
            end
            if (w_hs && !w_beat_last && dense_last_i) begin
                r_state <= ST_PAD;
            end else if ((r_state == ST_PAD) && w_beat_last) begin
                r_state <= ST_ENC;
            end
            // Clear has priority over the end-of-chunk advance.
            if (chunk_cnt_clr_i) begin
                r_chunk <= '0;
            end else if (w_chunk_end) begin
                r_chunk <= (r_chunk == CW'(SRAM_NUM - 1)) ? '0 : r_chunk + CW'(1);
            end
        end
    end

    // Output register: data is zero when idle, counts hold their last values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
            r_map         <= '0;
            r_data        <= '0;
            r_dat_count   <= '0;
            r_chunk_count <= '0;
        end else begin
            r_valid <= w_emit;
            r_done  <= w_chunk_end;
            r_map   <= w_hs ? w_map : '0;
            r_data  <= w_hs ? w_packed : '0;
            if (w_emit) begin
                r_dat_count   <= r_beat;
                r_chunk_count <= r_chunk;
            end
        end
    end

    assign sram_wr_valid_o        = r_valid;
    assign chunk_done_o           = r_done;
    assign sram_wr_sparsemap_o    = r_map;
    assign sram_wr_nonzero_data_o = r_data;
    assign sram_wr_dat_count_o    = r_dat_count;
    assign sram_wr_chunk_count_o  = r_chunk_count;

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Directed bench for sparse_chunk_encoder with BUS_SIZE=8, 4 beats/chunk, 4 slots.
// Observed output vector layout: {valid, done, dat_count[1:0], chunk_count[1:0], sparsemap[7:0], data[63:0]}.
module tb_sparse_chunk_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dense_valid = 1'b0;
    logic        dense_last = 1'b0;
    logic        clr = 1'b0;
    logic [63:0] dense_dat = '0;
    logic        dense_ready;
    logic        wr_valid;
    logic [7:0]  wr_map;
    logic [63:0] wr_data;
    logic [1:0]  wr_dat;
    logic [1:0]  wr_chunk;
    logic        done;
    logic [77:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sparse_chunk_encoder #(
        .BUS_SIZE(8),
        .WR_DAT_CYC_NUM(4),
        .SRAM_NUM(4)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dense_valid_i         (dense_valid),
        .dense_ready_o         (dense_ready),
        .dense_dat_i           (dense_dat),
        .dense_last_i          (dense_last),
        .chunk_cnt_clr_i       (clr),
        .sram_wr_valid_o       (wr_valid),
        .sram_wr_sparsemap_o   (wr_map),
        .sram_wr_nonzero_data_o(wr_data),
        .sram_wr_dat_count_o   (wr_dat),
        .sram_wr_chunk_count_o (wr_chunk),
        .chunk_done_o          (done)
    );

    assign obs = {wr_valid, done, wr_dat, wr_chunk, wr_map, wr_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dense_valid = 1'b0;
        dense_last  = 1'b0;
        clr         = 1'b0;
        dense_dat   = '0;
        rst         = 1'b1;
        tick();
        tick();
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        logic [77:0] e;
        #2 rst = 1'b1;
        #1;
        e = '0;
        n_total++;
        if (obs !== e) $display("FAIL reset_outputs got=%h exp=%h", obs, e);
        else n_pass++;
        n_total++;
        if (dense_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", dense_ready);
        else n_pass++;
        dense_valid = 1'b1;
        dense_dat   = 64'h1234;
        tick();
        tick();
        n_total++;
        if (obs !== e) $display("FAIL reset_held got=%h exp=%h", obs, e);
        else n_pass++;
        dense_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if (dense_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", dense_ready);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        logic [77:0] e;
        do_reset();
        dense_valid = 1'b1;
        dense_dat   = 64'h00_07_00_00_05_00_03_00;
        tick();
        e = {1'b1, 1'b0, 2'd0, 2'd0, 8'b0100_1010, 64'h0000_0000_0007_0503};
        n_total++;
        if (obs !== e) $display("FAIL single_beat got=%h exp=%h", obs, e);
        else n_pass++;
        dense_dat = 64'h8800_0000_0000_0011;
        tick();
        e = {1'b1, 1'b0, 2'd1, 2'd0, 8'h81, 64'h0000_0000_0000_8811};
        n_total++;
        if (obs !== e) $display("FAIL edge_bytes got=%h exp=%h", obs, e);
        else n_pass++;
        dense_dat = '0;
        tick();
        e = {1'b1, 1'b0, 2'd2, 2'd0, 8'h00, 64'h0};
        n_total++;
        if (obs !== e) $display("FAIL all_zero_beat got=%h exp=%h", obs, e);
        else n_pass++;
        dense_valid = 1'b0;
        tick();
        e = {1'b0, 1'b0, 2'd2, 2'd0, 8'h00, 64'h0};
        n_total++;
        if (obs !== e) $display("FAIL idle_after_single got=%h exp=%h", obs, e);
        else n_pass++;
        $display("test_single_beat done");
    endtask

    task automatic test_full_chunk();
        logic [77:0] e;
        do_reset();
        dense_valid = 1'b1;
        dense_dat   = {64{1'b1}};
        for (int b = 0; b < 4; b++) begin
            tick();
            e = {1'b1, (b == 3), 2'(b), 2'd0, 8'hFF, {64{1'b1}}};
            n_total++;
            if (obs !== e) $display("FAIL full_chunk_beat%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
        end
        tick();
        e = {1'b1, 1'b0, 2'd0, 2'd1, 8'hFF, {64{1'b1}}};
        n_total++;
        if (obs !== e) $display("FAIL next_chunk_slot got=%h exp=%h", obs, e);
        else n_pass++;
        dense_valid = 1'b0;
        tick();
        e = {1'b0, 1'b0, 2'd0, 2'd1, 8'h00, 64'h0};
        n_total++;
        if (obs !== e) $display("FAIL full_chunk_idle got=%h exp=%h", obs, e);
        else n_pass++;
        $display("test_full_chunk done");
    endtask

    task automatic test_short_pad();
        logic [77:0] e;
        do_reset();
        dense_valid = 1'b1;
        dense_last  = 1'b1;
        dense_dat   = 64'h0000_0000_0000_00AB;
        tick();
        e = {1'b1, 1'b0, 2'd0, 2'd0, 8'h01, 64'h0000_0000_0000_00AB};
        n_total++;
        if (obs !== e) $display("FAIL pad_first_beat got=%h exp=%h", obs, e);
        else n_pass++;
        n_total++;
        if (dense_ready !== 1'b0) $display("FAIL pad_ready_beat0 got=%b exp=0", dense_ready);
        else n_pass++;
        // Keep valid high with new data; it must not be taken until padding ends.
        dense_last = 1'b0;
        dense_dat  = 64'h5500_0000_0000_0000;
        for (int k = 1; k < 4; k++) begin
            tick();
            e = {1'b1, (k == 3), 2'(k), 2'd0, 8'h00, 64'h0};
            n_total++;
            if (obs !== e) $display("FAIL pad_beat%0d got=%h exp=%h", k, obs, e);
            else n_pass++;
            n_total++;
            if (dense_ready !== (k == 3)) $display("FAIL pad_ready%0d got=%b exp=%b", k, dense_ready, (k == 3));
            else n_pass++;
        end
        tick();
        e = {1'b1, 1'b0, 2'd0, 2'd1, 8'h80, 64'h0000_0000_0000_0055};
        n_total++;
        if (obs !== e) $display("FAIL pad_reaccept got=%h exp=%h", obs, e);
        else n_pass++;
        dense_valid = 1'b0;
        $display("test_short_pad done");
    endtask

    task automatic test_wrap_clear();
        logic [77:0] e;
        logic [7:0]  v;
        logic [1:0]  exp_chunk;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            for (int b = 0; b < 4; b++) begin
                v = 8'(c * 4 + b + 1);
                dense_valid = 1'b1;
                dense_dat   = {8{v}};
                clr         = (c == 5) && (b == 3);
                tick();
                clr = 1'b0;
                exp_chunk = (c < 5) ? 2'(c % 4) : ((c == 5) ? 2'd1 : 2'd0);
                e = {1'b1, (b == 3), 2'(b), exp_chunk, 8'hFF, {8{v}}};
                n_total++;
                if (obs !== e) $display("FAIL wrap_c%0d_b%0d got=%h exp=%h", c, b, obs, e);
                else n_pass++;
            end
        end
        dense_valid = 1'b0;
        $display("test_wrap_clear done");
    endtask

    task automatic test_gapped();
        logic [77:0] e;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            dense_valid = 1'b1;
            dense_dat   = 64'(b + 1) << (8 * b);
            tick();
            e = {1'b1, (b == 3), 2'(b), 2'd0, 8'(1 << b), 64'(b + 1)};
            n_total++;
            if (obs !== e) $display("FAIL gap_beat%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
            dense_valid = 1'b0;
            tick();
            e = {1'b0, 1'b0, 2'(b), 2'd0, 8'h00, 64'h0};
            n_total++;
            if (obs !== e) $display("FAIL gap_idle%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
        end
        $display("test_gapped done");
    endtask

    task automatic test_reset_mid();
        logic [77:0] e;
        do_reset();
        dense_valid = 1'b1;
        dense_dat   = 64'h1;
        for (int i = 0; i < 6; i++) tick();
        e = {1'b1, 1'b0, 2'd1, 2'd1, 8'h01, 64'h1};
        n_total++;
        if (obs !== e) $display("FAIL pre_reset got=%h exp=%h", obs, e);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        e = '0;
        n_total++;
        if (obs !== e) $display("FAIL async_reset got=%h exp=%h", obs, e);
        else n_pass++;
        n_total++;
        if (dense_ready !== 1'b0) $display("FAIL async_reset_ready got=%b exp=0", dense_ready);
        else n_pass++;
        tick();
        rst       = 1'b0;
        dense_dat = 64'h0200;
        tick();
        e = {1'b1, 1'b0, 2'd0, 2'd0, 8'h02, 64'h02};
        n_total++;
        if (obs !== e) $display("FAIL post_reset_beat got=%h exp=%h", obs, e);
        else n_pass++;
        dense_valid = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_full_chunk();
        test_short_pad();
        test_wrap_clear();
        test_gapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
